// File: rtl/frame_config_pkg.sv
// rtl/frame_config_pkg.sv - shared constants and state type for the frame configuration loader
package frame_config_pkg;

    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

    localparam logic [3:0] OP_DESYNC = 4'h0;
    localparam logic [3:0] OP_WRITE  = 4'h1;

    localparam int HDR_OP_MSB    = 31;
    localparam int HDR_OP_LSB    = 28;
    localparam int HDR_COL_MSB   = 27;
    localparam int HDR_COL_LSB   = 20;
    localparam int HDR_FRAME_MSB = 19;
    localparam int HDR_FRAME_LSB = 12;

    typedef enum logic [2:0] {
        UNSYNC,
        HEADER,
        DATA,
        CHECK,
        STROBE
    } state_e;

endpackage

// File: rtl/frame_strobe_decoder.sv
// rtl/frame_strobe_decoder.sv - one-hot FrameStrobe decode from (column, frame, fire)
// Out-of-range addresses decode to all-zero so the output is never more than one-hot.
module frame_strobe_decoder #(
    parameter int NUM_COLUMNS        = 16,
    parameter int MAX_FRAMES_PER_COL = 20
) (
    input  logic [7:0]                                column_i,
    input  logic [7:0]                                frame_i,
    input  logic                                      fire_i,
    output logic [NUM_COLUMNS*MAX_FRAMES_PER_COL-1:0] strobe_o
);

    localparam int NUM_STROBES = NUM_COLUMNS * MAX_FRAMES_PER_COL;

    logic in_range;
    int   sel_idx;

    assign in_range = (int'(column_i) < NUM_COLUMNS) && (int'(frame_i) < MAX_FRAMES_PER_COL);
    assign sel_idx  = int'(column_i) * MAX_FRAMES_PER_COL + int'(frame_i);

    always_comb begin
        strobe_o = '0;
        for (int i = 0; i < NUM_STROBES; i++) begin
            strobe_o[i] = fire_i && in_range && (i == sel_idx);
        end
    end

endmodule

// File: rtl/frame_config_loader.sv
// rtl/frame_config_loader.sv - parses sync/header/data words and drives FrameData/FrameStrobe
// Optional per-frame XOR checksum word enabled by defining FRAME_CONFIG_CHECKSUM_EN.
module frame_config_loader
    import frame_config_pkg::*;
#(
    parameter int NUM_ROWS           = 16,
    parameter int NUM_COLUMNS        = 16,
    parameter int MAX_FRAMES_PER_COL = 20
) (
    input  logic                                      CLK,
    input  logic                                      RESET,
    input  logic [31:0]                               s_data,
    input  logic                                      s_valid,
    output logic                                      s_ready,
    output logic [NUM_ROWS*32-1:0]                    FrameData,
    output logic [NUM_COLUMNS*MAX_FRAMES_PER_COL-1:0] FrameStrobe,
    output logic                                      synced,
    output logic                                      error,
    output logic [15:0]                               frames_written
);

    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    state_e                 state_q, state_d;
    logic [7:0]             col_q, col_d;
    logic [7:0]             frame_q, frame_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic                   addr_bad_q, addr_bad_d;
    logic [NUM_ROWS*32-1:0] data_q, data_d;
    logic                   synced_q, synced_d;
    logic                   error_q, error_d;
    logic [15:0]            count_q, count_d;
`ifdef FRAME_CONFIG_CHECKSUM_EN
    logic [31:0]            csum_q, csum_d;
`endif

    logic       accept;
    logic [3:0] hdr_op;
    logic [7:0] hdr_col;
    logic [7:0] hdr_frame;
    logic       hdr_bad;

    assign s_ready   = !RESET && (state_q != STROBE);
    assign accept    = s_valid && s_ready;
    assign hdr_op    = s_data[HDR_OP_MSB:HDR_OP_LSB];
    assign hdr_col   = s_data[HDR_COL_MSB:HDR_COL_LSB];
    assign hdr_frame = s_data[HDR_FRAME_MSB:HDR_FRAME_LSB];
    assign hdr_bad   = (int'(hdr_col) >= NUM_COLUMNS) || (int'(hdr_frame) >= MAX_FRAMES_PER_COL);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= UNSYNC;
            col_q      <= '0;
            frame_q    <= '0;
            row_q      <= '0;
            addr_bad_q <= 1'b0;
            data_q     <= '0;
            synced_q   <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= '0;
`ifdef FRAME_CONFIG_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            frame_q    <= frame_d;
            row_q      <= row_d;
            addr_bad_q <= addr_bad_d;
            data_q     <= data_d;
            synced_q   <= synced_d;
            error_q    <= error_d;
            count_q    <= count_d;
`ifdef FRAME_CONFIG_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        frame_d    = frame_q;
        row_d      = row_q;
        addr_bad_d = addr_bad_q;
        data_d     = data_q;
        synced_d   = synced_q;
        error_d    = error_q;
        count_d    = count_q;
`ifdef FRAME_CONFIG_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            UNSYNC: begin
                if (accept && (s_data == SYNC_WORD)) begin
                    state_d  = HEADER;
                    synced_d = 1'b1;
                    error_d  = 1'b0;
                    count_d  = '0;
                end
            end
            HEADER: begin
                if (accept) begin
                    if (s_data == SYNC_WORD) begin
                        error_d = 1'b0;
                    end else if (hdr_op == OP_WRITE) begin
                        col_d      = hdr_col;
                        frame_d    = hdr_frame;
                        row_d      = '0;
                        addr_bad_d = hdr_bad;
                        if (hdr_bad) begin
                            error_d = 1'b1;
                        end
`ifdef FRAME_CONFIG_CHECKSUM_EN
                        csum_d     = '0;
`endif
                        state_d    = DATA;
                    end else if (hdr_op == OP_DESYNC) begin
                        state_d  = UNSYNC;
                        synced_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    for (int r = 0; r < NUM_ROWS; r++) begin
                        if (row_q == ROW_W'(r)) begin
                            data_d[r*32 +: 32] = s_data;
                        end
                    end
`ifdef FRAME_CONFIG_CHECKSUM_EN
                    csum_d = csum_q ^ s_data;
                    if (row_q == LAST_ROW) begin
                        state_d = CHECK;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
`else
                    // A bad address still swallows its data words but never strobes.
                    if (row_q == LAST_ROW) begin
                        state_d = addr_bad_q ? HEADER : STROBE;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
`endif
                end
            end
`ifdef FRAME_CONFIG_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    if (s_data != csum_q) begin
                        error_d = 1'b1;
                        state_d = HEADER;
                    end else begin
                        state_d = addr_bad_q ? HEADER : STROBE;
                    end
                end
            end
`endif
            STROBE: begin
                state_d = HEADER;
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
            end
            default: state_d = UNSYNC;
        endcase
    end

    frame_strobe_decoder #(
        .NUM_COLUMNS        (NUM_COLUMNS),
        .MAX_FRAMES_PER_COL (MAX_FRAMES_PER_COL)
    ) u_strobe_decoder (
        .column_i (col_q),
        .frame_i  (frame_q),
        .fire_i   (state_q == STROBE),
        .strobe_o (FrameStrobe)
    );

    assign FrameData      = data_q;
    assign synced         = synced_q;
    assign error          = error_q;
    assign frames_written = count_q;

endmodule
